// File: rtl/uart_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_master
// Brief    : Streams bytes between valid/ready ports and an APB UART slave.
//            Optional TX retry on slave error: UART_APB_MASTER_ERR_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_master #(
   parameter int                    ADDR_WIDTH   = 5,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] TX_DATA_ADDR = 'h14,
   parameter logic [ADDR_WIDTH-1:0] RX_DATA_ADDR = 'h18,
   parameter int                    RX_HOLDOFF   = 2,
   parameter int                    RETRY_GAP    = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [7:0]              tx_data_i,
   input  logic                    tx_valid_i,
   output logic                    tx_ready_o,
   output logic [7:0]              rx_data_o,
   output logic                    rx_valid_o,
   input  logic                    rx_ready_i,
   input  logic                    rx_avail_i,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic                    pready_i,
   input  logic                    pslverr_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   output logic                    err_o,
   output logic                    busy_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int HOLD_W = (RX_HOLDOFF > 1) ? $clog2(RX_HOLDOFF + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_SETUP      = 2'd1,
      S_ACCESS     = 2'd2,
      S_RETRY_WAIT = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_tx_full;
   logic [7:0]          r_tx_data;
   logic                r_rx_valid;
   logic [7:0]          r_rx_data;
   logic [HOLD_W-1:0]   r_holdoff_cnt;
   logic                r_last_grant_tx;
   logic                r_is_write;
   logic                r_err;
   logic                w_tx_req;
   logic                w_rx_req;
   logic                w_grant_tx;
   logic                w_grant_rx;
   logic                w_done;
   logic                w_unused;

`ifdef UART_APB_MASTER_ERR_RETRY_EN
   localparam int RETRY_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;
   logic [RETRY_W-1:0]  r_retry_cnt;
   assign w_unused = ^prdata_i[DATA_WIDTH-1:8];
`else
   assign w_unused = ^{prdata_i[DATA_WIDTH-1:8], RETRY_GAP[0]};
`endif

   // Round-robin: whoever was not served last wins a tie.
   assign w_tx_req   = r_tx_full;
   assign w_rx_req   = rx_avail_i && !r_rx_valid && (r_holdoff_cnt == '0);
   assign w_grant_tx = w_tx_req && (!w_rx_req || !r_last_grant_tx);
   assign w_grant_rx = w_rx_req && !w_grant_tx;
   assign w_done     = (r_state == S_ACCESS) && pready_i;

   assign tx_ready_o = !r_tx_full;
   assign rx_valid_o = r_rx_valid;
   assign rx_data_o  = r_rx_data;
   assign err_o      = r_err;
   assign busy_o     = (r_state != S_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      psel_o      = 1'b0;
      penable_o   = 1'b0;
      pwrite_o    = 1'b0;
      paddr_o     = '0;
      pwdata_o    = '0;
      pstrb_o     = '0;
      if (r_state == S_SETUP || r_state == S_ACCESS) begin
         psel_o   = 1'b1;
         pwrite_o = r_is_write;
         paddr_o  = r_is_write ? TX_DATA_ADDR : RX_DATA_ADDR;
         pwdata_o = r_is_write ? DATA_WIDTH'(r_tx_data) : '0;
         pstrb_o  = r_is_write ? STRB_W'(1) : '0;
      end
      case (r_state)
         S_IDLE:   if (w_grant_tx || w_grant_rx) w_state_nxt = S_SETUP;
         S_SETUP:  w_state_nxt = S_ACCESS;
         S_ACCESS: begin
            penable_o = 1'b1;
            if (pready_i) begin
               w_state_nxt = S_IDLE;
`ifdef UART_APB_MASTER_ERR_RETRY_EN
               if (r_is_write && pslverr_i) w_state_nxt = S_RETRY_WAIT;
`endif
            end
         end
`ifdef UART_APB_MASTER_ERR_RETRY_EN
         S_RETRY_WAIT: if (r_retry_cnt <= RETRY_W'(1)) w_state_nxt = S_IDLE;
`endif
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_full       <= 1'b0;
         r_tx_data       <= '0;
         r_rx_valid      <= 1'b0;
         r_rx_data       <= '0;
         r_holdoff_cnt   <= '0;
         r_last_grant_tx <= 1'b0;
         r_is_write      <= 1'b0;
         r_err           <= 1'b0;
`ifdef UART_APB_MASTER_ERR_RETRY_EN
         r_retry_cnt     <= '0;
`endif
      end else begin
         r_err <= 1'b0;
         if (r_holdoff_cnt != '0) r_holdoff_cnt <= r_holdoff_cnt - HOLD_W'(1);
         if (tx_valid_i && !r_tx_full) begin
            r_tx_full <= 1'b1;
            r_tx_data <= tx_data_i;
         end
         if (r_rx_valid && rx_ready_i) r_rx_valid <= 1'b0;
         if (r_state == S_IDLE && (w_grant_tx || w_grant_rx)) begin
            r_is_write      <= w_grant_tx;
            r_last_grant_tx <= w_grant_tx;
         end
         if (w_done) begin
            if (r_is_write) begin
`ifdef UART_APB_MASTER_ERR_RETRY_EN
               if (pslverr_i) r_retry_cnt <= RETRY_W'(RETRY_GAP);
               else           r_tx_full   <= 1'b0;
`else
               r_tx_full <= 1'b0;
               r_err     <= pslverr_i;
`endif
            end else begin
               if (pslverr_i) begin
                  r_err <= 1'b1;
               end else begin
                  r_rx_data  <= prdata_i[7:0];
                  r_rx_valid <= 1'b1;
               end
               r_holdoff_cnt <= HOLD_W'(RX_HOLDOFF);
            end
         end
`ifdef UART_APB_MASTER_ERR_RETRY_EN
         if (r_state == S_RETRY_WAIT && r_retry_cnt != '0)
            r_retry_cnt <= r_retry_cnt - RETRY_W'(1);
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_master
// Brief    : Scoreboard bench for uart_apb_master with a simple APB slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_master;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  tx_data_i = '0;
   logic        tx_valid_i = 1'b0;
   logic        tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        rx_ready_i = 1'b0;
   logic        rx_avail_i = 1'b0;
   logic        psel_o, penable_o, pwrite_o;
   logic [4:0]  paddr_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic        pready_i = 1'b1;
   logic        pslverr_i = 1'b0;
   logic [31:0] prdata_i = '0;
   logic        err_o, busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_wr_q[$];
   logic [7:0] exp_rx_q[$];

   always #5 clk_i = ~clk_i;

   uart_apb_master dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .rx_avail_i(rx_avail_i),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
      .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
      .err_o(err_o), .busy_o(busy_o)
   );

   task automatic do_reset;
      @(posedge clk_i); #1;
      rst_i = 1'b1; tx_valid_i = 1'b0; rx_avail_i = 1'b0; rx_ready_i = 1'b0;
      pready_i = 1'b1; pslverr_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   // Returns at the negedge where the requested APB phase is visible.
   task automatic wait_apb(input bit access, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_i);
         if (psel_o === 1'b1 && penable_o === access) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin
         n_bad++; $display("FAIL reset_ctrl: got %b required 000", {psel_o, penable_o, pwrite_o});
      end
      n_cmp++;
      if ({paddr_o, pwdata_o, pstrb_o} !== 41'h0) begin
         n_bad++; $display("FAIL reset_bus: got %h required 0", {paddr_o, pwdata_o, pstrb_o});
      end
      n_cmp++;
      if ({tx_ready_o, rx_valid_o, rx_data_o, err_o, busy_o} !== 12'h800) begin
         n_bad++; $display("FAIL reset_status: got %h required 800",
                           {tx_ready_o, rx_valid_o, rx_data_o, err_o, busy_o});
      end
      @(posedge clk_i); #1 rst_i = 1'b0;
   endtask

   task automatic test_tx_basic;
      logic [7:0] e;
      pready_i = 1'b1; pslverr_i = 1'b0;
      @(posedge clk_i); #1;
      tx_data_i = 8'hA5; tx_valid_i = 1'b1; exp_wr_q.push_back(8'hA5);
      @(posedge clk_i); #1 tx_valid_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({psel_o, tx_ready_o, busy_o} !== 3'b000) begin
         n_bad++; $display("FAIL tx_cycle1: got %b required 000", {psel_o, tx_ready_o, busy_o});
      end
      @(negedge clk_i);
      n_cmp++;
      if ({psel_o, penable_o, pwrite_o, paddr_o, pstrb_o} !== {3'b101, 5'h14, 4'b0001}) begin
         n_bad++; $display("FAIL tx_setup: got %h required %h",
                           {psel_o, penable_o, pwrite_o, paddr_o, pstrb_o}, {3'b101, 5'h14, 4'b0001});
      end
      e = exp_wr_q.pop_front();
      n_cmp++;
      if (pwdata_o !== {24'h0, e}) begin
         n_bad++; $display("FAIL tx_pwdata: got %h required %h", pwdata_o, {24'h0, e});
      end
      @(negedge clk_i);
      n_cmp++;
      if ({psel_o, penable_o, tx_ready_o} !== 3'b110) begin
         n_bad++; $display("FAIL tx_access: got %b required 110", {psel_o, penable_o, tx_ready_o});
      end
      @(negedge clk_i);
      n_cmp++;
      if ({tx_ready_o, psel_o, busy_o} !== 3'b100) begin
         n_bad++; $display("FAIL tx_done: got %b required 100", {tx_ready_o, psel_o, busy_o});
      end
   endtask

   task automatic test_wait_states;
      logic [7:0]  e;
      logic [41:0] snap;
      bit          ok;
      int          pen;
      bit          stable;
      pready_i = 1'b0;
      @(posedge clk_i); #1;
      tx_data_i = 8'h5A; tx_valid_i = 1'b1; exp_wr_q.push_back(8'h5A);
      @(posedge clk_i); #1 tx_valid_i = 1'b0;
      wait_apb(1'b0, 10, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL ws_setup_timeout: got none required setup"); end
      e = exp_wr_q.pop_front();
      n_cmp++;
      if (pwdata_o !== {24'h0, e}) begin
         n_bad++; $display("FAIL ws_pwdata: got %h required %h", pwdata_o, {24'h0, e});
      end
      snap = {pwrite_o, paddr_o, pwdata_o, pstrb_o};
      pen = 0; stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (penable_o === 1'b1) pen++;
         if ({pwrite_o, paddr_o, pwdata_o, pstrb_o} !== snap || psel_o !== 1'b1 || tx_ready_o !== 1'b0)
            stable = 1'b0;
         if (i == 3) pready_i = 1'b1;
      end
      n_cmp++;
      if (pen != 4) begin n_bad++; $display("FAIL ws_penable_cycles: got %0d required 4", pen); end
      n_cmp++;
      if (!stable) begin n_bad++; $display("FAIL ws_stable: got 0 required 1"); end
      @(negedge clk_i);
      n_cmp++;
      if ({psel_o, penable_o, tx_ready_o} !== 3'b001) begin
         n_bad++; $display("FAIL ws_done: got %b required 001", {psel_o, penable_o, tx_ready_o});
      end
   endtask

   task automatic test_arbitration;
      logic [7:0] e;
      bit         ok;
      bit         hold_ok;
      do_reset();
      prdata_i = 32'hFFFF_FF3C;
      tx_data_i = 8'hC3; tx_valid_i = 1'b1; exp_wr_q.push_back(8'hC3);
      @(posedge clk_i); #1;
      tx_valid_i = 1'b0; rx_avail_i = 1'b1; exp_rx_q.push_back(8'h3C);
      wait_apb(1'b0, 10, ok);
      e = exp_wr_q.pop_front();
      n_cmp++;
      if (!ok || {pwrite_o, paddr_o, pwdata_o} !== {1'b1, 5'h14, 24'h0, e}) begin
         n_bad++; $display("FAIL arb_first_write: got %h required %h",
                           {pwrite_o, paddr_o, pwdata_o}, {1'b1, 5'h14, 24'h0, e});
      end
      wait_apb(1'b0, 10, ok);
      n_cmp++;
      if (!ok || {pwrite_o, paddr_o, pwdata_o, pstrb_o} !== {1'b0, 5'h18, 36'h0}) begin
         n_bad++; $display("FAIL arb_second_read: got %h required %h",
                           {pwrite_o, paddr_o, pwdata_o, pstrb_o}, {1'b0, 5'h18, 36'h0});
      end
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (rx_valid_o === 1'b1) begin ok = 1'b1; break; end
      end
      e = exp_rx_q.pop_front();
      n_cmp++;
      if (!ok || rx_data_o !== e) begin
         n_bad++; $display("FAIL arb_rx_data: got %h valid %b required %h", rx_data_o, rx_valid_o, e);
      end
      prdata_i = 32'h0000_005D;
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         if (rx_valid_o !== 1'b1 || rx_data_o !== e || psel_o !== 1'b0) hold_ok = 1'b0;
      end
      n_cmp++;
      if (!hold_ok) begin n_bad++; $display("FAIL arb_rx_hold: got 0 required 1"); end
   endtask

   task automatic test_holdoff;
      logic [7:0] e;
      bit         ok;
      int         gap;
      rx_ready_i = 1'b1;
      exp_rx_q.push_back(8'h5D);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_i);
         if (rx_valid_o === 1'b1) begin ok = 1'b1; break; end
      end
      e = exp_rx_q.pop_front();
      n_cmp++;
      if (!ok || rx_data_o !== e) begin
         n_bad++; $display("FAIL hold_rx_data: got %h valid %b required %h", rx_data_o, rx_valid_o, e);
      end
      gap = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk_i);
         if (psel_o === 1'b1) begin gap = i; break; end
      end
      n_cmp++;
      if (gap != 3) begin n_bad++; $display("FAIL hold_gap: got %0d required 3", gap); end
      rx_avail_i = 1'b0;
      repeat (8) @(negedge clk_i);
      rx_ready_i = 1'b0;
   endtask

   task automatic test_rx_err;
      bit ok;
      pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h99; rx_avail_i = 1'b1;
      wait_apb(1'b1, 10, ok);
      @(negedge clk_i);
      rx_avail_i = 1'b0; pslverr_i = 1'b0;
      n_cmp++;
      if (!ok || {err_o, rx_valid_o} !== 2'b10) begin
         n_bad++; $display("FAIL rxerr_pulse: got %b required 10", {err_o, rx_valid_o});
      end
      @(negedge clk_i);
      n_cmp++;
      if ({err_o, rx_valid_o} !== 2'b00) begin
         n_bad++; $display("FAIL rxerr_after: got %b required 00", {err_o, rx_valid_o});
      end
   endtask

   task automatic test_tx_err;
      logic [7:0] e;
      bit         ok;
      int         errs;
      logic       rdy_after;
      pready_i = 1'b1; pslverr_i = 1'b1;
      @(posedge clk_i); #1;
      tx_data_i = 8'h77; tx_valid_i = 1'b1; exp_wr_q.push_back(8'h77);
      @(posedge clk_i); #1 tx_valid_i = 1'b0;
      wait_apb(1'b1, 10, ok);
      e = exp_wr_q.pop_front();
      n_cmp++;
      if (!ok || pwdata_o !== {24'h0, e}) begin
         n_bad++; $display("FAIL txerr_write: got %h required %h", pwdata_o, {24'h0, e});
      end
      @(negedge clk_i);
      pslverr_i = 1'b0;
      rdy_after = tx_ready_o;
      errs = (err_o === 1'b1) ? 1 : 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_i);
         if (err_o === 1'b1) errs++;
      end
`ifdef UART_APB_MASTER_ERR_RETRY_EN
      n_cmp++;
      if (errs != 0) begin n_bad++; $display("FAIL txerr_no_pulse: got %0d required 0", errs); end
      n_cmp++;
      if (rdy_after !== 1'b0) begin n_bad++; $display("FAIL txerr_held: got %b required 0", rdy_after); end
      wait_apb(1'b0, 40, ok);
      n_cmp++;
      if (!ok || pwdata_o !== {24'h0, e}) begin
         n_bad++; $display("FAIL txerr_retry: got %h required %h", pwdata_o, {24'h0, e});
      end
      repeat (3) @(negedge clk_i);
`else
      n_cmp++;
      if (errs != 1) begin n_bad++; $display("FAIL txerr_pulse: got %0d required 1", errs); end
      n_cmp++;
      if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL txerr_ready: got %b required 1", rdy_after); end
`endif
   endtask

   task automatic test_reset_mid;
      bit ok;
      bit quiet;
      pready_i = 1'b0;
      @(posedge clk_i); #1;
      tx_data_i = 8'h3E; tx_valid_i = 1'b1;
      @(posedge clk_i); #1 tx_valid_i = 1'b0;
      wait_apb(1'b1, 10, ok);
      rst_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (!ok || {psel_o, penable_o, tx_ready_o, busy_o} !== 4'b0010) begin
         n_bad++; $display("FAIL rstmid: got %b required 0010", {psel_o, penable_o, tx_ready_o, busy_o});
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0; pready_i = 1'b1;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk_i);
         if (psel_o !== 1'b0) quiet = 1'b0;
      end
      n_cmp++;
      if (!quiet) begin n_bad++; $display("FAIL rstmid_discard: got 0 required 1"); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] bytes [3];
      logic [7:0] e;
      int         idx, setups, last_cyc;
      bit         hs, spacing_ok;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      idx = 0; setups = 0; last_cyc = 0; spacing_ok = 1'b1;
      pready_i = 1'b1;
      @(posedge clk_i); #1;
      tx_data_i = bytes[0]; tx_valid_i = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk_i);
         hs = tx_valid_i && (tx_ready_o === 1'b1);
         if (hs) exp_wr_q.push_back(tx_data_i);
         if (psel_o === 1'b1 && penable_o === 1'b0) begin
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
               n_bad++; $display("FAIL b2b_unexpected: got %h required none", pwdata_o);
            end else begin
               e = exp_wr_q.pop_front();
               if (pwdata_o !== {24'h0, e}) begin
                  n_bad++; $display("FAIL b2b_data: got %h required %h", pwdata_o, {24'h0, e});
               end
            end
            if (setups > 0 && cyc - last_cyc != 4) spacing_ok = 1'b0;
            last_cyc = cyc;
            setups++;
            if (setups == 3) break;
         end
         @(posedge clk_i); #1;
         if (hs) begin
            idx++;
            if (idx < 3) tx_data_i = bytes[idx];
            else         tx_valid_i = 1'b0;
         end
      end
      tx_valid_i = 1'b0;
      n_cmp++;
      if (setups != 3) begin n_bad++; $display("FAIL b2b_count: got %0d required 3", setups); end
      n_cmp++;
      if (!spacing_ok) begin n_bad++; $display("FAIL b2b_spacing: got irregular required 4"); end
      repeat (4) @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_wait_states();
      test_arbitration();
      test_holdoff();
      test_rx_err();
      test_tx_err();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
